// File: rtl/hash_ctx_bank_pkg.sv
// hash_ctx_bank_pkg: shared word width, SHA-256/SHA-224 IVs and the command/readout enums.
package hash_ctx_bank_pkg;
    localparam int WORD = 32;
    localparam logic [255:0] IV256 = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
    localparam logic [255:0] IV224 = 256'hc1059ed8_367cd507_3070dd17_f70e5939_ffc00b31_68581511_64f98fa7_befa4fa4;
    typedef enum logic {CMD_INIT, CMD_ACCUM} cmd_op_e;
    typedef enum logic {RD_IDLE, RD_SEND} rd_state_e;
endpackage

// File: rtl/hash_ctx_regs.sv
// hash_ctx_regs: one H0..H7 context with IV load and modulo-2^32 accumulate.
// SHA224_EN adds a stored mode bit selecting the SHA-224 IV and a 7-word readout.
module hash_ctx_regs
    import hash_ctx_bank_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 we,
    input  cmd_op_e              op,
    input  logic                 mode,
    input  logic [7:0][WORD-1:0] state,
    output logic [7:0][WORD-1:0] h,
    output logic                 live,
    output logic                 mode_224
);
    logic [7:0][WORD-1:0] h_d, h_q;
    logic live_d, live_q;
    logic [255:0] iv;
`ifdef SHA224_EN
    logic mode_d, mode_q;
    assign iv = mode ? IV224 : IV256;
    assign mode_d = (we && op == CMD_INIT) ? mode : mode_q;
    assign mode_224 = mode_q;
    always_ff @(posedge clk or posedge rst)
        if (rst) mode_q <= 1'b0;
        else     mode_q <= mode_d;
`else
    logic unused_mode;
    assign unused_mode = mode;
    assign iv = IV256;
    assign mode_224 = 1'b0;
`endif
    // H0 sits in the top word so the packed layout matches {A..H} on cmd_state.
    always_comb begin
        h_d = h_q;
        live_d = live_q;
        if (we && op == CMD_INIT) begin
            h_d = iv;
            live_d = 1'b1;
        end else if (we) begin
            for (int k = 0; k < 8; k++) h_d[k] = h_q[k] + state[k];
        end
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            h_q <= '0;
            live_q <= 1'b0;
        end else begin
            h_q <= h_d;
            live_q <= live_d;
        end
    assign h = h_q;
    assign live = live_q;
endmodule

// File: rtl/hash_ctx_bank.sv
// hash_ctx_bank: NUM_CTX SHA-256 intermediate-hash contexts with a word-serial digest readout.
// Define SHA224_EN to honour cmd_mode and store a per-context SHA-224 mode bit.
module hash_ctx_bank
    import hash_ctx_bank_pkg::*;
#(
    parameter int NUM_CTX = 4,
    parameter int CTX_W   = $clog2(NUM_CTX) > 0 ? $clog2(NUM_CTX) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic               cmd_op,
    input  logic [CTX_W-1:0]   cmd_ctx,
    input  logic               cmd_mode,
    input  logic [255:0]       cmd_state,
    output logic               cmd_err,
    output logic [NUM_CTX-1:0] ctx_live,
    input  logic               rd_valid,
    output logic               rd_ready,
    input  logic [CTX_W-1:0]   rd_ctx,
    output logic               dout_valid,
    input  logic               dout_ready,
    output logic [WORD-1:0]    dout_word,
    output logic               dout_last
);
    localparam int NPAD = 2 ** CTX_W;
    rd_state_e state_d, state_q;
    logic [CTX_W-1:0] cur_d, cur_q;
    logic [2:0] idx_d, idx_q, last;
    logic cmd_fire, cmd_err_d, cmd_err_q;
    logic [7:0][WORD-1:0] h_pad [NPAD];
    logic [NPAD-1:0] m224_pad, ctx_ok;

    assign cmd_ready = !(state_q == RD_SEND && cmd_ctx == cur_q);
    assign cmd_fire = cmd_valid && cmd_ready;
    assign cmd_err_d = cmd_fire && !ctx_ok[cmd_ctx];

    // Index space is padded to a power of two; unused slots read as zero and flag errors.
    for (genvar i = 0; i < NPAD; i++) begin : g_ctx
        if (i < NUM_CTX) begin : g_real
            assign ctx_ok[i] = 1'b1;
            hash_ctx_regs u_regs (
                .clk      (clk),
                .rst      (rst),
                .we       (cmd_fire && cmd_ctx == CTX_W'(i)),
                .op       (cmd_op_e'(cmd_op)),
                .mode     (cmd_mode),
                .state    (cmd_state),
                .h        (h_pad[i]),
                .live     (ctx_live[i]),
                .mode_224 (m224_pad[i])
            );
        end else begin : g_pad
            assign ctx_ok[i] = 1'b0;
            assign h_pad[i] = '0;
            assign m224_pad[i] = 1'b0;
        end
    end

    assign last = m224_pad[cur_q] ? 3'd6 : 3'd7;
    assign rd_ready = state_q == RD_IDLE;
    assign dout_valid = state_q == RD_SEND;
    assign dout_last = dout_valid && idx_q == last;
    assign dout_word = dout_valid ? h_pad[cur_q][3'd7 - idx_q] : '0;
    assign cmd_err = cmd_err_q;

    always_comb begin
        state_d = state_q;
        cur_d = cur_q;
        idx_d = idx_q;
        if (state_q == RD_IDLE && rd_valid) begin
            state_d = RD_SEND;
            cur_d = rd_ctx;
            idx_d = 3'd0;
        end else if (state_q == RD_SEND && dout_ready) begin
            state_d = idx_q == last ? RD_IDLE : RD_SEND;
            idx_d = idx_q + 3'd1;
        end
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state_q <= RD_IDLE;
            cur_q <= '0;
            idx_q <= '0;
            cmd_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cur_q <= cur_d;
            idx_q <= idx_d;
            cmd_err_q <= cmd_err_d;
        end
endmodule

// File: tb/tb_hash_ctx_bank.sv
// tb_hash_ctx_bank: directed checks of hash_ctx_bank (4-context and 3-context instances).
module tb_hash_ctx_bank;
    localparam logic [255:0] E256 = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
    localparam logic [255:0] E224 = 256'hc1059ed8_367cd507_3070dd17_f70e5939_ffc00b31_68581511_64f98fa7_befa4fa4;
    localparam logic [255:0] ACC  = 256'h95f61999_00000001_00000001_00000001_00000001_00000001_00000001_00000001;
    localparam logic [255:0] EACC = 256'h00000000_bb67ae86_3c6ef373_a54ff53b_510e5280_9b05688d_1f83d9ac_5be0cd1a;

    logic clk = 1'b0, rst = 1'b1;
    logic cmd_valid = 0, cmd_op = 0, cmd_mode = 0, rd_valid = 0, dout_ready = 0;
    logic [1:0] cmd_ctx = 0, rd_ctx = 0;
    logic [255:0] cmd_state = '0;
    logic cmd_ready, cmd_err, rd_ready, dout_valid, dout_last;
    logic [3:0] ctx_live;
    logic [31:0] dout_word;

    logic c3_valid = 0, c3_op = 0, r3_valid = 0, d3_ready = 0;
    logic [1:0] c3_ctx = 0, r3_ctx = 0;
    logic [255:0] c3_state = '0;
    logic c3_ready, c3_err, r3_ready, d3_valid, d3_last;
    logic [2:0] live3;
    logic [31:0] d3_word;

    int n_cmp = 0, n_err = 0;

    always #5 clk = ~clk;

    hash_ctx_bank #(.NUM_CTX(4)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_ctx(cmd_ctx), .cmd_mode(cmd_mode), .cmd_state(cmd_state), .cmd_err(cmd_err),
        .ctx_live(ctx_live), .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_ctx(rd_ctx),
        .dout_valid(dout_valid), .dout_ready(dout_ready), .dout_word(dout_word), .dout_last(dout_last)
    );

    hash_ctx_bank #(.NUM_CTX(3)) u3 (
        .clk(clk), .rst(rst), .cmd_valid(c3_valid), .cmd_ready(c3_ready), .cmd_op(c3_op),
        .cmd_ctx(c3_ctx), .cmd_mode(1'b0), .cmd_state(c3_state), .cmd_err(c3_err),
        .ctx_live(live3), .rd_valid(r3_valid), .rd_ready(r3_ready), .rd_ctx(r3_ctx),
        .dout_valid(d3_valid), .dout_ready(d3_ready), .dout_word(d3_word), .dout_last(d3_last)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_cmd(input logic op, input logic [1:0] ctx, input logic mode, input logic [255:0] st);
        cmd_valid = 1; cmd_op = op; cmd_ctx = ctx; cmd_mode = mode; cmd_state = st;
        tick();
        cmd_valid = 0;
    endtask

    task automatic start_rd(input logic [1:0] ctx);
        rd_valid = 1; rd_ctx = ctx;
        #1 chk("rd_ready_idle", rd_ready, 1);
        tick();
        rd_valid = 0;
    endtask

    task automatic drain(input string tag, input logic [255:0] exp, input int n, input bit stall);
        int k = 0;
        for (int cyc = 0; cyc < 60 && k < n; cyc++) begin
            dout_ready = stall ? (cyc % 3 == 0) : 1'b1;
            #1;
            chk({tag, "_valid"}, dout_valid, 1);
            chk({tag, "_word"}, dout_word, exp[255 - 32*k -: 32]);
            chk({tag, "_last"}, dout_last, k == n - 1);
            if (dout_ready) k++;
            tick();
        end
        dout_ready = 0;
        chk({tag, "_count"}, k, n);
        chk({tag, "_idle"}, dout_valid, 0);
    endtask

    initial begin
        tick(); tick();
        rst = 0;
        tick();
        chk("rst_dout_valid", dout_valid, 0);
        chk("rst_dout_word", dout_word, 0);
        chk("rst_dout_last", dout_last, 0);
        chk("rst_cmd_err", cmd_err, 0);
        chk("rst_ctx_live", ctx_live, 4'b0000);
        chk("rst_cmd_ready", cmd_ready, 1);

        do_cmd(0, 2'd0, 0, '0);
        chk("live_ctx0", ctx_live, 4'b0001);
        start_rd(2'd0);
        drain("t1_ctx0", E256, 8, 0);

        do_cmd(0, 2'd1, 0, '0);
        do_cmd(1, 2'd1, 0, ACC);
        chk("t2_no_err", cmd_err, 0);
        start_rd(2'd1);
        drain("t2_ctx1", EACC, 8, 0);
        start_rd(2'd0);
        drain("t2_ctx0", E256, 8, 0);

        do_cmd(0, 2'd2, 0, '0);
        start_rd(2'd2);
        cmd_valid = 1; cmd_op = 0; cmd_ctx = 2'd2; cmd_mode = 0;
        #1 chk("t3_block_ctx2", cmd_ready, 0);
        cmd_ctx = 2'd3;
        #1 chk("t3_pass_ctx3", cmd_ready, 1);
        drain("t3_ctx2", E256, 8, 1);
        cmd_valid = 0;
        chk("t3_live", ctx_live, 4'b1111);
        start_rd(2'd3);
        drain("t3_ctx3", E256, 8, 0);

        chk("t4_live3_init", live3, 3'b000);
        c3_valid = 1; c3_op = 1; c3_ctx = 2'd3; c3_state = ACC;
        tick();
        c3_valid = 0;
        chk("t4_err_pulse", c3_err, 1);
        tick();
        chk("t4_err_drop", c3_err, 0);
        c3_valid = 1; c3_op = 1; c3_ctx = 2'd0; c3_state = 256'h12345678 << 224;
        tick();
        c3_valid = 0;
        chk("t4_no_err_ctx0", c3_err, 0);
        chk("t4_live3_accum", live3, 3'b000);
        r3_valid = 1; r3_ctx = 2'd0;
        tick();
        r3_valid = 0;
        chk("t4_rd0_word", d3_word, 32'h12345678);
        d3_ready = 1;
        for (int i = 0; i < 8; i++) tick();
        d3_ready = 0;
        chk("t4_rd0_done", d3_valid, 0);
        r3_valid = 1; r3_ctx = 2'd3;
        tick();
        r3_valid = 0;
        chk("t4_rd3_valid", d3_valid, 1);
        chk("t4_rd3_word", d3_word, 0);
        d3_ready = 1;
        for (int i = 0; i < 7; i++) tick();
        chk("t4_rd3_last", d3_last, 1);
        tick();
        d3_ready = 0;
        chk("t4_rd3_done", d3_valid, 0);

        do_cmd(0, 2'd0, 1, '0);
        start_rd(2'd0);
`ifdef SHA224_EN
        drain("t5_224", E224, 7, 0);
`else
        drain("t5_256", E256, 8, 0);
`endif

        start_rd(2'd1);
        dout_ready = 1;
        tick(); tick();
        dout_ready = 0;
        chk("t6_word3", dout_word, EACC[191:160]);
        rst = 1;
        #1;
        chk("t6_async_valid", dout_valid, 0);
        chk("t6_live", ctx_live, 4'b0000);
        tick();
        rst = 0;
        tick();
        chk("t6_rd_ready", rd_ready, 1);
        chk("t6_valid_after", dout_valid, 0);
        start_rd(2'd1);
        drain("t6_zero", '0, 8, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
